// File: rtl/m_ifetch_buf.sv
// Instruction prefetch buffer: single-outstanding fetch engine feeding a DEPTH-entry FIFO.
// Optional same-cycle ack-to-ID bypass enabled by defining IFB_BYPASS_EN.
module m_ifetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   w_redirect,
  input  logic [31:0]            w_tpc,
  input  logic                   w_halt,
  output logic                   r_mreq,
  output logic [AW-1:0]          r_maddr,
  input  logic                   w_mack,
  input  logic [31:0]            w_mdata,
  output logic                   w_valid,
  output logic [31:0]            w_ir,
  output logic [31:0]            w_pc,
  output logic [31:0]            w_pc4,
  input  logic                   w_stall,
  output logic [$clog2(DEPTH):0] r_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0020;

  logic [31:0]   q_ir [DEPTH];
  logic [31:0]   q_pc [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_fpc;
  logic          r_drop;

  logic          ack;
  logic          take;
  logic          empty;
  logic          byp;
  logic          push;
  logic          pop;
  logic          hold_req;
  logic          room;
  logic [CW:0]   occ;
  logic [31:0]   fpc_nxt;

  assign ack      = w_mack & r_mreq;
  assign take     = ack & ~r_drop & ~w_redirect;
  assign empty    = (r_count == '0);
`ifdef IFB_BYPASS_EN
  assign byp      = empty & take;
`else
  assign byp      = 1'b0;
`endif
  assign pop      = ~empty & ~w_stall & ~w_redirect;
  // A bypassed word that ID accepts this cycle never enters storage.
  assign push     = take & ~(byp & ~w_stall);
  assign hold_req = r_mreq & ~w_mack;
  // The in-flight request is counted as occupancy so its push can never overflow.
  assign occ      = {1'b0, r_count} + {{CW{1'b0}}, r_mreq};
  assign room     = (occ < (CW+1)'(DEPTH));

  always_comb begin
    fpc_nxt = r_fpc;
    if (w_redirect)
      fpc_nxt = w_tpc & 32'hFFFF_FFFC;
    else if (take)
      fpc_nxt = r_fpc + 32'd4;
  end

  always_comb begin
    w_valid = ~empty | byp;
    w_ir    = NOP;
    w_pc    = r_fpc;
    if (!empty) begin
      w_ir = q_ir[r_rptr];
      w_pc = q_pc[r_rptr];
    end else if (byp) begin
      w_ir = w_mdata;
      w_pc = r_fpc;
    end
    w_pc4 = w_pc + 32'd4;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_fpc   <= '0;
      r_mreq  <= 1'b0;
      r_maddr <= '0;
      r_drop  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_fpc  <= fpc_nxt;
      r_mreq <= hold_req | (room & ~w_halt & ~w_redirect);
      // Address is frozen while a request waits for its ack.
      if (!hold_req)
        r_maddr <= fpc_nxt[AW+1:2];
      if (ack)
        r_drop <= 1'b0;
      else if (w_redirect && r_mreq)
        r_drop <= 1'b1;
      if (w_redirect) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        r_wptr  <= r_wptr + PW'(push);
        r_rptr  <= r_rptr + PW'(pop);
        r_count <= r_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (push) begin
      q_ir[r_wptr] <= w_mdata;
      q_pc[r_wptr] <= r_fpc;
    end
  end

endmodule

// File: doc/m_ifetch_buf.md
M_IFETCH_BUF -- requirements
Module: m_ifetch_buf

Interface
REQ-001 Parameter DEPTH, 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 Parameter AW, 12, instruction-memory word-address width.
REQ-003 w_clk  in  1  sole clock, all state on posedge.
REQ-004 w_rst  in  1  reset, asynchronous, active-high.
REQ-005 w_redirect  in  1  branch taken from ID stage; flush and refetch.
REQ-006 w_tpc  in  32  redirect target byte address; bits [1:0] ignored.
REQ-007 w_halt  in  1  stop issuing new fetches (level).
REQ-008 r_mreq  out  1  fetch request to instruction memory.
REQ-009 r_maddr  out  AW  word address, equals fetch pc[AW+1:2].
REQ-010 w_mack  in  1  memory acknowledge; w_mdata valid this cycle.
REQ-011 w_mdata  in  32  instruction word.
REQ-012 w_valid  out  1  head instruction available to ID.
REQ-013 w_ir  out  32  head instruction; NOP 32'h00000020 when not valid.
REQ-014 w_pc, w_pc4  out  32 each  head instruction address and address+4.
REQ-015 w_stall  in  1  ID not ready; head must not be consumed.
REQ-016 r_count  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Block SHALL hold fetch pointer r_fpc (32b); r_maddr = r_fpc[AW+1:2].
REQ-018 At most one outstanding request; r_mreq and r_maddr SHALL stay stable from assertion until the cycle w_mack=1.
REQ-019 r_mreq SHALL assert next cycle when r_count + outstanding < DEPTH and w_halt=0 and w_redirect=0.
REQ-020 On w_mack with no pending drop: push {r_fpc, w_mdata}, r_fpc += 4.
REQ-021 Pop SHALL occur when w_valid=1 and w_stall=0; push and pop in the same cycle leave r_count unchanged.
REQ-022 w_valid = (r_count != 0); w_ir/w_pc/w_pc4 SHALL be the head entry (combinational from storage).
REQ-023 Push into a full FIFO SHALL never occur (guaranteed by REQ-019); read/write pointers wrap modulo DEPTH.
REQ-024 w_redirect=1: FIFO emptied, r_fpc <= {w_tpc[31:2],2'b00}, no pop that cycle; redirect wins over simultaneous push/pop.
REQ-025 Redirect while a request is outstanding: that request still completes its handshake, its data SHALL be discarded (drop flag), and the new fetch issues the cycle after its ack.
REQ-026 Redirect in the same cycle as w_mack: data discarded, drop flag not set.
REQ-027 w_halt=1: no new request; an outstanding request completes and is pushed; FIFO drains normally.
REQ-028 r_fpc wraps 32'hFFFFFFFC -> 0 with no flag.

Reset
REQ-029 w_rst asserted at any time, including mid-handshake: r_fpc=0, FIFO empty, r_count=0, r_mreq=0, outstanding=0, drop=0, w_valid=0, w_ir=NOP, w_pc=0, w_pc4=4.
REQ-030 First request SHALL assert on the first posedge after w_rst deasserts, r_maddr=0.

Configuration
REQ-031 Macro IFB_BYPASS_EN: when defined, if FIFO empty and w_mack=1 with no drop, w_valid=1 and w_ir/w_pc/w_pc4 SHALL present w_mdata/r_fpc/r_fpc+4 that cycle; if w_stall=0 the entry is consumed and not pushed, otherwise it is pushed.
REQ-032 Without IFB_BYPASS_EN: minimum ack-to-w_valid latency is exactly 1 cycle; no combinational path w_mack/w_mdata -> w_valid/w_ir.

Verification
REQ-033 Reset release, memory acks in 1 cycle, w_stall=0 -> w_pc sequence 0,4,8,...; w_ir matches memory words in order.
REQ-034 w_stall=1 held 10 cycles, zero-wait memory -> r_count stops at 4, r_mreq=0, r_maddr=4 after 4 pushes; release -> pc 0,4,8,12 delivered, no loss.
REQ-035 Memory latency 3 cycles, w_redirect with w_tpc=32'h40 mid-request for addr 8 -> addr-8 data dropped, next w_valid shows w_pc=32'h40.
REQ-036 w_redirect and w_mack same cycle, w_tpc=32'h103 -> data dropped, next r_maddr=12'h040, w_pc=32'h100.
REQ-037 w_rst pulsed while r_mreq=1 and r_count=3 -> all outputs per REQ-029 immediately, refetch from 0.
REQ-038 With IFB_BYPASS_EN, empty FIFO, w_mack with w_mdata=32'h2014000A -> w_valid=1 and w_ir=32'h2014000A same cycle, r_count stays 0.
